// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit.
package mem_access_unit_pkg;

   localparam int          MEM_AW   = 17;
   localparam logic [31:0] ZEROWORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   // Misaligned half/word or the reserved size code.
   function automatic logic access_err(input size_e size, input logic [1:0] lane);
      logic err;
      case (size)
         SIZE_BYTE: err = 1'b0;
         SIZE_HALF: err = lane[0];
         SIZE_WORD: err = |lane;
         default:   err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extraction with extension, and sub-word store merge.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  size_e       size_i,
   input  logic        signed_i,
   input  logic [15:0] sdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select lane, extend for loads, splice store data into the old word.
   always_comb begin
      byte_sel = word_i[{lane_i, 3'b000} +: 8];
      half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
      load_o   = word_i;
      merge_o  = word_i;
      case (size_i)
         SIZE_BYTE: begin
            load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            merge_o[{lane_i, 3'b000} +: 8] = sdata_i[7:0];
         end
         SIZE_HALF: begin
            load_o = {{16{signed_i & half_sel[15]}}, half_sel};
            if (lane_i[1]) merge_o[31:16] = sdata_i;
            else           merge_o[15:0]  = sdata_i;
         end
         default: begin
            load_o  = word_i;
            merge_o = word_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Core-side initiator for the word-only data memory. Sub-word stores are
// done as read-modify-write since the memory has no byte enables.
//
//   state    | meaning
//   ST_IDLE  | ready for a request, memory port parked at zero
//   ST_READ  | memory word captured into the holding register
//   ST_WRITE | mem_we high, full or merged word driven
//   ST_DONE  | one-cycle response pulse
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_store_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_signed_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              resp_valid_o,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_err_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   state_e            state_q, state_d;
   logic              store_q, signed_q, err_q;
   size_e             size_q;
   logic [MEM_AW+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       hold_q;

   logic              accept;
   size_e             size_in;
   logic              err_in;
   logic [31:0]       load_val;
   logic [31:0]       merge_val;
   logic              unused_addr_hi;

   // Only the word-index and lane bits of the address reach the memory.
   assign unused_addr_hi = ^req_addr_i[ADDR_W-1:MEM_AW+2];

   assign size_in = size_e'(req_size_i);
   assign err_in  = access_err(size_in, req_addr_i[1:0]);
   assign accept  = req_valid_i && req_ready_o;

   mem_lane_align u_align (
      .word_i   (hold_q),
      .lane_i   (addr_q[1:0]),
      .size_i   (size_q),
      .signed_i (signed_q),
      .sdata_i  (wdata_q[15:0]),
      .load_o   (load_val),
      .merge_o  (merge_val)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Request latch; inputs are don't-care once accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         store_q  <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= SIZE_BYTE;
         addr_q   <= '0;
         wdata_q  <= ZEROWORD;
      end else if (accept) begin
         store_q  <= req_store_i;
         signed_q <= req_signed_i;
         err_q    <= err_in;
         size_q   <= size_in;
         addr_q   <= req_addr_i[MEM_AW+1:0];
         wdata_q  <= req_wdata_i;
      end
   end

   // Holding word for sub-word loads and the read half of read-modify-write.
   always_ff @(posedge clock) begin
      if (reset)                  hold_q <= ZEROWORD;
      else if (state_q == ST_READ) hold_q <= mem_rdata_i;
   end

   // Next state and outputs; everything forced idle while reset is high.
   always_comb begin
      state_d      = state_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_rdata_o = ZEROWORD;
      resp_err_o   = 1'b0;
      mem_addr_o   = '0;
      mem_we_o     = 1'b0;
      mem_wdata_o  = ZEROWORD;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = !reset;
            if (accept) begin
               if (err_in)                     state_d = ST_DONE;
               else if (!req_store_i)          state_d = ST_READ;
               else if (size_in == SIZE_WORD)  state_d = ST_WRITE;
               else                            state_d = ST_READ;
            end
         end
         ST_READ: begin
            mem_addr_o = addr_q[MEM_AW+1:2];
            state_d    = store_q ? ST_WRITE : ST_DONE;
         end
         ST_WRITE: begin
            mem_addr_o  = addr_q[MEM_AW+1:2];
            mem_we_o    = 1'b1;
            mem_wdata_o = (size_q == SIZE_WORD) ? wdata_q : merge_val;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            mem_addr_o   = addr_q[MEM_AW+1:2];
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
            if (!err_q && !store_q) resp_rdata_o = load_val;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (reset) begin
         resp_valid_o = 1'b0;
         resp_rdata_o = ZEROWORD;
         resp_err_o   = 1'b0;
         mem_addr_o   = '0;
         mem_we_o     = 1'b0;
         mem_wdata_o  = ZEROWORD;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [16:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:63];

   int n_cmp = 0;
   int n_bad = 0;

   int          r_lat, r_nwe, r_we_cyc;
   logic [31:0] r_rdata, r_we_data;
   logic [16:0] r_we_addr;
   logic        r_err;

   mem_access_unit dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_store_i  (req_store),
      .req_size_i   (req_size),
      .req_signed_i (req_signed),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid),
      .resp_rdata_o (resp_rdata),
      .resp_err_o   (resp_err),
      .mem_addr_o   (mem_addr),
      .mem_we_o     (mem_we),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata)
   );

   always #5 clock = ~clock;

   assign mem_rdata = mem[mem_addr[5:0]];

   always @(posedge clock) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[3] = 32'h1122_3344;
      mem[5] = 32'h8899_AABB;
      mem[7] = 32'hAABB_CCDD;
      mem[9] = 32'h5566_7788;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, then watch up to 6 cycles for writes and the response.
   task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd);
      @(negedge clock);
      chk("ready_before_req", {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_store  = st;
      req_size   = sz;
      req_signed = sg;
      req_addr   = ad;
      req_wdata  = wd;
      @(posedge clock);
      #1;
      req_valid  = 1'b0;
      req_store  = ~st;
      req_size   = ~sz;
      req_signed = ~sg;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      r_lat = 0; r_nwe = 0; r_we_cyc = 0;
      r_rdata = 32'h0; r_we_data = 32'h0; r_we_addr = 17'h0; r_err = 1'b0;
      for (int c = 1; c <= 6 && r_lat == 0; c++) begin
         @(negedge clock);
         if (mem_we) begin
            r_nwe++;
            r_we_cyc  = c;
            r_we_addr = mem_addr;
            r_we_data = mem_wdata;
         end
         if (resp_valid) begin
            r_lat   = c;
            r_rdata = resp_rdata;
            r_err   = resp_err;
         end
      end
   endtask

   initial begin
      int nwe, nresp;

      @(negedge clock);
      chk("rst_ready",  {31'b0, req_ready},  32'd0);
      chk("rst_we",     {31'b0, mem_we},     32'd0);
      chk("rst_resp",   {31'b0, resp_valid}, 32'd0);
      chk("rst_addr",   32'(mem_addr),       32'd0);
      chk("rst_wdata",  mem_wdata,           32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

      // lb 0x15 -> lane 1 of 0x8899AABB = 0xAA, sign-extended
      issue(1'b0, 2'b00, 1'b1, 32'h15, 32'h0);
      chk("lb_lat",   r_lat,   2);
      chk("lb_data",  r_rdata, 32'hFFFF_FFAA);
      chk("lb_err",   {31'b0, r_err}, 32'd0);
      chk("lb_nwe",   r_nwe,   0);

      // lbu 0x17 -> 0x88 zero-extended
      issue(1'b0, 2'b00, 1'b0, 32'h17, 32'h0);
      chk("lbu_data", r_rdata, 32'h0000_0088);

      // lhu 0x16 -> upper half 0x8899
      issue(1'b0, 2'b01, 1'b0, 32'h16, 32'h0);
      chk("lhu_lat",  r_lat,   2);
      chk("lhu_data", r_rdata, 32'h0000_8899);

      // lh 0x14 -> lower half 0xAABB sign-extended
      issue(1'b0, 2'b01, 1'b1, 32'h14, 32'h0);
      chk("lh_data",  r_rdata, 32'hFFFF_AABB);

      // sb 0x0D 0xEE into 0x11223344 -> 0x1122EE44
      issue(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_00EE);
      chk("sb_lat",    r_lat,     3);
      chk("sb_nwe",    r_nwe,     1);
      chk("sb_wecyc",  r_we_cyc,  2);
      chk("sb_weaddr", 32'(r_we_addr), 32'd3);
      chk("sb_wdata",  r_we_data, 32'h1122_EE44);
      chk("sb_rdata",  r_rdata,   32'h0);
      chk("sb_mem",    mem[3],    32'h1122_EE44);

      // sh 0x1E 0x1234CAFE into 0xAABBCCDD -> 0xCAFECCDD
      issue(1'b1, 2'b01, 1'b0, 32'h1E, 32'h1234_CAFE);
      chk("sh_lat",   r_lat,     3);
      chk("sh_wdata", r_we_data, 32'hCAFE_CCDD);

      // sw 0x20 -> write in cycle 1 at word 8
      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
      chk("sw_lat",    r_lat,     2);
      chk("sw_wecyc",  r_we_cyc,  1);
      chk("sw_weaddr", 32'(r_we_addr), 32'd8);
      chk("sw_wdata",  r_we_data, 32'hDEAD_BEEF);

      // lw readback
      issue(1'b0, 2'b10, 1'b1, 32'h20, 32'h0);
      chk("lw_lat",  r_lat,   2);
      chk("lw_data", r_rdata, 32'hDEAD_BEEF);

      // misaligned lw 0x22
      issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
      chk("lwmis_lat",  r_lat,   1);
      chk("lwmis_err",  {31'b0, r_err}, 32'd1);
      chk("lwmis_data", r_rdata, 32'h0);
      chk("lwmis_nwe",  r_nwe,   0);

      // illegal size store
      issue(1'b1, 2'b11, 1'b0, 32'h00, 32'h1234_5678);
      chk("ill_lat", r_lat, 1);
      chk("ill_err", {31'b0, r_err}, 32'd1);
      chk("ill_nwe", r_nwe, 0);
      chk("ill_mem", mem[0], 32'h0);

      // misaligned sh 0x15
      issue(1'b1, 2'b01, 1'b0, 32'h15, 32'h0000_FFFF);
      chk("shmis_err", {31'b0, r_err}, 32'd1);
      chk("shmis_nwe", r_nwe, 0);
      chk("shmis_mem", mem[5], 32'h8899_AABB);

      // sh 0x24, reset asserted during READ
      @(negedge clock);
      req_valid = 1'b1; req_store = 1'b1; req_size = 2'b01; req_signed = 1'b0;
      req_addr  = 32'h24; req_wdata = 32'h0000_FFFF;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clock);
      chk("abort_we",    {31'b0, mem_we},     32'd0);
      chk("abort_resp",  {31'b0, resp_valid}, 32'd0);
      chk("abort_ready", {31'b0, req_ready},  32'd0);
      @(negedge clock);
      reset = 1'b0;
      nwe = 0; nresp = 0;
      @(negedge clock);
      chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
      for (int c = 0; c < 4; c++) begin
         if (mem_we)     nwe++;
         if (resp_valid) nresp++;
         @(negedge clock);
      end
      chk("abort_nwe",  nwe,    0);
      chk("abort_nresp", nresp, 0);
      chk("abort_mem",  mem[9], 32'h5566_7788);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
